fsm_triple_sink: RTL

Receiving end for the three-word result stream emitted by the generated FSM test modules. It accepts 32-bit words one per valid/ready handshake, assembles them into a triple, and classifies each triple against two parameterised expected triples: the "then" and "else" branch results. It keeps saturating frame and error counters. It sits in the unit-test bench fabric as the self-checking sink for compiled FSMs.

---
 rtl/fsm_sink_pkg.sv | 22 ++
 rtl/fsm_triple_sink_sat_counter.sv | 25 ++
 rtl/fsm_triple_sink.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/fsm_sink_pkg.sv
// rtl/fsm_sink_pkg.sv - shared states, defaults and saturating helper for fsm_triple_sink
package fsm_sink_pkg;

   // Default widths for the data path and the frame/error counters
   localparam int unsigned WIDTH_DEF     = 32;
   localparam int unsigned CNT_WIDTH_DEF = 8;

   // Receive FSM encoding (2-bit)
   typedef logic [1:0] state_t;
   localparam state_t S_WORD0  = 2'd0;
   localparam state_t S_WORD1  = 2'd1;
   localparam state_t S_WORD2  = 2'd2;
   localparam state_t S_REPORT = 2'd3;

   // Increment that sticks at the all-ones value of a width-bit counter (width <= 32)
   function automatic logic [31:0] sat_inc(input logic [31:0] value, input int unsigned width);
      logic [31:0] max_value;
      max_value = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
      return (value >= max_value) ? value : value + 32'd1;
   endfunction

endpackage

// File: rtl/fsm_triple_sink_sat_counter.sv
// rtl/fsm_triple_sink_sat_counter.sv - saturating event counter with synchronous clear
module sat_counter
   import fsm_sink_pkg::*;
#(
   parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 inc,
   input  logic                 clear,
   output logic [CNT_WIDTH-1:0] count
);

   // Count up on inc, hold at all-ones, clear on request or reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (inc) begin
         count <= CNT_WIDTH'(sat_inc(32'(count), CNT_WIDTH));
      end
   end

endmodule

// File: rtl/fsm_triple_sink.sv
// rtl/fsm_triple_sink.sv - three-word result sink that classifies triples against A/B
module fsm_triple_sink
   import fsm_sink_pkg::*;
#(
   parameter int unsigned WIDTH     = WIDTH_DEF,
   parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF,
   parameter int unsigned EXP_A0    = 1,
   parameter int unsigned EXP_A1    = 3,
   parameter int unsigned EXP_A2    = 1,
   parameter int unsigned EXP_B0    = 2,
   parameter int unsigned EXP_B1    = 5,
   parameter int unsigned EXP_B2    = 7
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   input  logic                 in_first,
   input  logic [WIDTH-1:0]     in_data,
   output logic                 in_ready,
   output logic [WIDTH-1:0]     word0,
   output logic [WIDTH-1:0]     word1,
   output logic [WIDTH-1:0]     word2,
   output logic                 triple_valid,
   output logic                 match_a,
   output logic                 match_b,
   output logic                 mismatch,
   output logic [CNT_WIDTH-1:0] frame_count,
   output logic [CNT_WIDTH-1:0] error_count,
   output logic                 sync_error
);

   state_t           state;
   logic [WIDTH-1:0] stage0;
   logic [WIDTH-1:0] stage1;
   logic             accept;
   logic             hit_a;
   logic             hit_b;
   logic             hit_none;
   logic             complete;
   logic             frame_err;
   logic             err_inc;

   // Ready is a pure decode of the state; the report cycle blocks input
   always_comb begin
      in_ready = (state != S_REPORT);
      accept   = in_valid && in_ready;
   end

   // Compare the would-be triple (two staged words plus the live word) against A and B
   always_comb begin
      hit_a    = (stage0 == WIDTH'(EXP_A0)) && (stage1 == WIDTH'(EXP_A1)) && (in_data == WIDTH'(EXP_A2));
      hit_b    = (stage0 == WIDTH'(EXP_B0)) && (stage1 == WIDTH'(EXP_B1)) && (in_data == WIDTH'(EXP_B2));
      hit_none = !(hit_a || hit_b);
   end

   // Event decode: a completed triple, or a framing violation; these never coincide
   always_comb begin
      complete  = accept && (state == S_WORD2) && !in_first;
      frame_err = accept && (((state == S_WORD0) && !in_first) ||
                             (((state == S_WORD1) || (state == S_WORD2)) && in_first));
      err_inc   = frame_err || (complete && hit_none);
   end

   // Receive FSM: stage words, resync on an unexpected first, publish the triple on word 2
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= S_WORD0;
         stage0       <= '0;
         stage1       <= '0;
         word0        <= '0;
         word1        <= '0;
         word2        <= '0;
         match_a      <= 1'b0;
         match_b      <= 1'b0;
         mismatch     <= 1'b0;
         triple_valid <= 1'b0;
         sync_error   <= 1'b0;
      end else begin
         case (state)
            S_WORD0: begin
               if (accept) begin
                  if (in_first) begin
                     stage0 <= in_data;
                     state  <= S_WORD1;
                  end else begin
                     sync_error <= 1'b1;
                  end
               end
            end
            S_WORD1: begin
               if (accept) begin
                  if (in_first) begin
                     stage0     <= in_data;
                     sync_error <= 1'b1;
                  end else begin
                     stage1 <= in_data;
                     state  <= S_WORD2;
                  end
               end
            end
            S_WORD2: begin
               if (accept) begin
                  if (in_first) begin
                     stage0     <= in_data;
                     sync_error <= 1'b1;
                     state      <= S_WORD1;
                  end else begin
                     word0        <= stage0;
                     word1        <= stage1;
                     word2        <= in_data;
                     match_a      <= hit_a;
                     match_b      <= hit_b;
                     mismatch     <= hit_none;
                     triple_valid <= 1'b1;
                     state        <= S_REPORT;
                  end
               end
            end
            S_REPORT: begin
               triple_valid <= 1'b0;
               state        <= S_WORD0;
            end
            default: begin
               triple_valid <= 1'b0;
               state        <= S_WORD0;
            end
         endcase
      end
   end

   sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_frame_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (complete),
      .clear (1'b0),
      .count (frame_count)
   );

   sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_error_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (err_inc),
      .clear (1'b0),
      .count (error_count)
   );

endmodule
